// File: rtl/jam_param_if.sv
// ============================================================================
// Module : jam_param_if
// Brief  : Host-side bus of the jam_param assignment-problem solver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface jam_param_if #(
    parameter int CW = 7
);
    logic            Start;
    logic [2:0]      W;
    logic [2:0]      J;
    logic [CW-1:0]   Cost;
    logic            Busy;
    logic            Valid;
    logic [CW+2:0]   MinCost;
    logic [15:0]     MatchCount;
    logic [23:0]     BestPerm;

    modport master (
        output Start, Cost,
        input  W, J, Busy, Valid, MinCost, MatchCount, BestPerm
    );

    modport slave (
        input  Start, Cost,
        output W, J, Busy, Valid, MinCost, MatchCount, BestPerm
    );
endinterface

`default_nettype wire

// File: rtl/jam_param.sv
// ============================================================================
// Module : jam_param
// Brief  : Exhaustive N-worker/N-job assignment solver over all N! permutations.
//          Optional macro JAM_BEST_PERM_EN keeps the best permutation register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jam_param #(
    parameter int N  = 8,
    parameter int CW = 7
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    jam_param_if.slave    bus
);
    localparam int         IW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [2:0] LAST   = 3'(N - 1);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_EVAL = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    row_q, col_q;
    logic [2:0]    idx_q;
    logic [CW+2:0] sum_q, min_q;
    logic [15:0]   cnt_q;
    logic [2:0]    perm_q [N];
    logic [CW-1:0] cost_q [N][N];

    logic [2:0]    perm_swp [N];
    logic [2:0]    perm_nxt [N];
    logic [IW-1:0] k_w, l_w;
    logic          last_w;
    logic [CW-1:0] term_w;
    logic [CW+2:0] sum_w;

    // Lexicographic successor of perm_q, produced in a single cycle
    always_comb begin
        k_w    = '0;
        l_w    = '0;
        last_w = 1'b1;
        for (int j = 0; j < N - 1; j++) begin
            if (perm_q[j] < perm_q[j+1]) begin
                k_w    = IW'(j);
                last_w = 1'b0;
            end
        end
        for (int j = 0; j < N; j++) begin
            if ((IW'(j) > k_w) && (perm_q[j] > perm_q[k_w]))
                l_w = IW'(j);
        end
        for (int j = 0; j < N; j++) begin
            if (IW'(j) == k_w)
                perm_swp[j] = perm_q[l_w];
            else if (IW'(j) == l_w)
                perm_swp[j] = perm_q[k_w];
            else
                perm_swp[j] = perm_q[j];
        end
        for (int j = 0; j < N; j++) begin
            if (IW'(j) > k_w)
                perm_nxt[j] = perm_swp[IW'(N + int'(k_w) - j)];
            else
                perm_nxt[j] = perm_swp[j];
        end
    end

    assign term_w = cost_q[idx_q[IW-1:0]][perm_q[idx_q[IW-1:0]][IW-1:0]];
    assign sum_w  = sum_q + {3'b000, term_w};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (bus.Start) state_d = S_LOAD;
            S_LOAD:         if (row_q == LAST && col_q == LAST) state_d = S_EVAL;
            S_EVAL:         if (idx_q == LAST) state_d = last_w ? S_DONE : S_NEXT;
            S_NEXT:         state_d = S_EVAL;
            default:        state_d = S_IDLE;
        endcase
    end

`ifdef JAM_BEST_PERM_EN
    logic [2:0] best_q [N];
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            min_q   <= '1;
            cnt_q   <= '0;
            for (int j = 0; j < N; j++) begin
                perm_q[j] <= 3'(j);
`ifdef JAM_BEST_PERM_EN
                best_q[j] <= '0;
`endif
                for (int m = 0; m < N; m++) cost_q[j][m] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.Start) begin
                        row_q <= '0;
                        col_q <= '0;
                        idx_q <= '0;
                        sum_q <= '0;
                        min_q <= '1;
                        cnt_q <= '0;
                        for (int j = 0; j < N; j++) begin
                            perm_q[j] <= 3'(j);
`ifdef JAM_BEST_PERM_EN
                            best_q[j] <= '0;
`endif
                        end
                    end
                end
                S_LOAD: begin
                    cost_q[row_q[IW-1:0]][col_q[IW-1:0]] <= bus.Cost;
                    if (col_q == LAST) begin
                        col_q <= '0;
                        row_q <= (row_q == LAST) ? 3'd0 : row_q + 3'd1;
                    end else begin
                        col_q <= col_q + 3'd1;
                    end
                end
                S_EVAL: begin
                    if (idx_q == LAST) begin
                        idx_q <= '0;
                        sum_q <= '0;
                        if (sum_w < min_q) begin
                            min_q <= sum_w;
                            cnt_q <= 16'd1;
`ifdef JAM_BEST_PERM_EN
                            for (int j = 0; j < N; j++) best_q[j] <= perm_q[j];
`endif
                        end else if (sum_w == min_q) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end else begin
                        idx_q <= idx_q + 3'd1;
                        sum_q <= sum_w;
                    end
                end
                S_NEXT: begin
                    for (int j = 0; j < N; j++) perm_q[j] <= perm_nxt[j];
                end
                default: ;
            endcase
        end
    end

    assign bus.W          = (state_q == S_LOAD) ? row_q : 3'd0;
    assign bus.J          = (state_q == S_LOAD) ? col_q : 3'd0;
    assign bus.Busy       = (state_q == S_LOAD) || (state_q == S_EVAL) || (state_q == S_NEXT);
    assign bus.Valid      = (state_q == S_DONE);
    assign bus.MinCost    = min_q;
    assign bus.MatchCount = cnt_q;

`ifdef JAM_BEST_PERM_EN
    for (genvar g = 0; g < 8; g++) begin : g_bp
        if (g < N) begin : g_used
            assign bus.BestPerm[3*g +: 3] = best_q[g];
        end else begin : g_pad
            assign bus.BestPerm[3*g +: 3] = 3'b000;
        end
    end
`else
    assign bus.BestPerm = 24'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jam_param.sv
// ============================================================================
// Module : tb_jam_param
// Brief  : Directed self-checking bench for jam_param at N = 2, 3, 4 and 6.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jam_param;
`ifdef JAM_BEST_PERM_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RST   = 1'b1;
    logic start = 1'b0;
    int   sel   = 4;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    jam_param_if #(.CW(7)) if2 ();
    jam_param_if #(.CW(7)) if3 ();
    jam_param_if #(.CW(7)) if4 ();
    jam_param_if #(.CW(7)) if6 ();

    jam_param #(.N(2), .CW(7)) u2 (.CLK(CLK), .RST(RST), .bus(if2));
    jam_param #(.N(3), .CW(7)) u3 (.CLK(CLK), .RST(RST), .bus(if3));
    jam_param #(.N(4), .CW(7)) u4 (.CLK(CLK), .RST(RST), .bus(if4));
    jam_param #(.N(6), .CW(7)) u6 (.CLK(CLK), .RST(RST), .bus(if6));

    assign if2.Start = start && (sel == 2);
    assign if3.Start = start && (sel == 3);
    assign if4.Start = start && (sel == 4);
    assign if6.Start = start && (sel == 6);

    // Cost tables: [[1,2],[3,4]]; 3i+j; anti-diagonal zeros; all 127
    assign if2.Cost = (if2.W == 3'd0) ? ((if2.J == 3'd0) ? 7'd1 : 7'd2)
                                      : ((if2.J == 3'd0) ? 7'd3 : 7'd4);
    assign if3.Cost = 7'(3 * int'(if3.W) + int'(if3.J));
    assign if4.Cost = (int'(if4.J) == 3 - int'(if4.W)) ? 7'd0 : 7'd10;
    assign if6.Cost = 7'd127;

    logic        cur_valid, cur_busy;
    logic [9:0]  cur_min;
    logic [15:0] cur_cnt;
    logic [23:0] cur_bp;
    logic [2:0]  cur_w, cur_j;

    always_comb begin
        cur_valid = if4.Valid; cur_busy = if4.Busy; cur_min = if4.MinCost;
        cur_cnt = if4.MatchCount; cur_bp = if4.BestPerm; cur_w = if4.W; cur_j = if4.J;
        case (sel)
            2: begin cur_valid = if2.Valid; cur_busy = if2.Busy; cur_min = if2.MinCost;
                     cur_cnt = if2.MatchCount; cur_bp = if2.BestPerm; cur_w = if2.W; cur_j = if2.J; end
            3: begin cur_valid = if3.Valid; cur_busy = if3.Busy; cur_min = if3.MinCost;
                     cur_cnt = if3.MatchCount; cur_bp = if3.BestPerm; cur_w = if3.W; cur_j = if3.J; end
            6: begin cur_valid = if6.Valid; cur_busy = if6.Busy; cur_min = if6.MinCost;
                     cur_cnt = if6.MatchCount; cur_bp = if6.BestPerm; cur_w = if6.W; cur_j = if6.J; end
            default: ;
        endcase
    end

    logic [2:0] wlog [0:64];
    logic [2:0] jlog [0:64];

    // Pulse Start, then follow the solve until Valid; optionally keep Start high while busy
    task automatic run(input int budget, input bit poke, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = poke;
        lat = 1;
        while (!cur_valid && lat < budget) begin
            if (!cur_busy) busy_ok = 1'b0;
            if (lat <= 64) begin wlog[lat] = cur_w; jlog[lat] = cur_j; end
            @(negedge CLK);
            lat++;
        end
        start = 1'b0;
        tests++;
        if (!cur_valid) begin
            fails++;
            $display("FAIL timeout sel=%0d: Valid never rose within %0d cycles", sel, budget);
        end
    endtask

    task automatic test_reset();
        sel = 4;
        repeat (3) @(negedge CLK);
        tests++; if (cur_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", cur_valid); end
        tests++; if (cur_busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", cur_busy); end
        tests++; if (cur_min !== 10'h3FF) begin fails++; $display("FAIL rst_min got %0d want 1023", cur_min); end
        tests++; if (cur_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got %0d want 0", cur_cnt); end
        tests++; if (cur_bp !== 24'd0) begin fails++; $display("FAIL rst_bp got %h want 0", cur_bp); end
        tests++; if ({cur_w, cur_j} !== 6'd0) begin fails++; $display("FAIL rst_wj got %0d,%0d want 0,0", cur_w, cur_j); end
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        tests++; if (cur_busy !== 1'b0 || cur_valid !== 1'b0) begin
            fails++; $display("FAIL idle_after_rst busy=%b valid=%b want 0,0", cur_busy, cur_valid); end
    endtask

    task automatic test_n2();
        int lat; bit bok;
        sel = 2;
        run(64, 1'b0, lat, bok);
        for (int i = 0; i < 5; i++) begin
            logic [2:0] ew, ej;
            ew = (i < 4) ? 3'(i / 2) : 3'd0;
            ej = (i < 4) ? 3'(i % 2) : 3'd0;
            tests++;
            if (wlog[i+1] !== ew || jlog[i+1] !== ej) begin
                fails++; $display("FAIL n2_wj[%0d] got %0d,%0d want %0d,%0d", i, wlog[i+1], jlog[i+1], ew, ej);
            end
        end
        tests++; if (!bok) begin fails++; $display("FAIL n2_busy got low want high before Valid"); end
        tests++; if (cur_busy !== 1'b0) begin fails++; $display("FAIL n2_busy_done got %b want 0", cur_busy); end
        tests++; if (lat > 24) begin fails++; $display("FAIL n2_latency got %0d want <=24", lat); end
        tests++; if (cur_min !== 10'd5) begin fails++; $display("FAIL n2_min got %0d want 5", cur_min); end
        tests++; if (cur_cnt !== 16'd2) begin fails++; $display("FAIL n2_cnt got %0d want 2", cur_cnt); end
        tests++; if (cur_bp !== (BP ? 24'h000008 : 24'd0)) begin
            fails++; $display("FAIL n2_bp got %h want %h", cur_bp, BP ? 24'h000008 : 24'd0); end
    endtask

    task automatic test_n3();
        int lat; bit bok;
        sel = 3;
        run(200, 1'b0, lat, bok);
        tests++; if (lat > 79) begin fails++; $display("FAIL n3_latency got %0d want <=79", lat); end
        tests++; if (cur_min !== 10'd12) begin fails++; $display("FAIL n3_min got %0d want 12", cur_min); end
        tests++; if (cur_cnt !== 16'd6) begin fails++; $display("FAIL n3_cnt got %0d want 6", cur_cnt); end
        tests++; if (cur_bp !== (BP ? 24'h000088 : 24'd0)) begin
            fails++; $display("FAIL n3_bp got %h want %h", cur_bp, BP ? 24'h000088 : 24'd0); end
    endtask

    task automatic test_n4(output int lat);
        bit bok;
        sel = 4;
        run(400, 1'b0, lat, bok);
        tests++; if (lat > 356) begin fails++; $display("FAIL n4_latency got %0d want <=356", lat); end
        tests++; if (cur_min !== 10'd0) begin fails++; $display("FAIL n4_min got %0d want 0", cur_min); end
        tests++; if (cur_cnt !== 16'd1) begin fails++; $display("FAIL n4_cnt got %0d want 1", cur_cnt); end
        tests++; if (cur_bp !== (BP ? 24'h000053 : 24'd0)) begin
            fails++; $display("FAIL n4_bp got %h want %h", cur_bp, BP ? 24'h000053 : 24'd0); end
        repeat (10) @(negedge CLK);
        tests++; if (cur_valid !== 1'b1 || cur_min !== 10'd0 || cur_cnt !== 16'd1) begin
            fails++; $display("FAIL n4_hold valid=%b min=%0d cnt=%0d want 1,0,1", cur_valid, cur_min, cur_cnt); end
    endtask

    task automatic test_start_during_next(input int ref_lat);
        int lat; bit bok;
        sel = 4;
        run(400, 1'b1, lat, bok);
        tests++; if (lat !== ref_lat) begin fails++; $display("FAIL poke_latency got %0d want %0d", lat, ref_lat); end
        tests++; if (!bok) begin fails++; $display("FAIL poke_busy got low want high before Valid"); end
        tests++; if (cur_min !== 10'd0 || cur_cnt !== 16'd1) begin
            fails++; $display("FAIL poke_result min=%0d cnt=%0d want 0,1", cur_min, cur_cnt); end
    endtask

    task automatic test_reset_mid_eval();
        int lat; bit bok;
        sel = 4;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (18) @(negedge CLK);
        RST = 1'b1;
        #1;
        tests++; if (cur_busy !== 1'b0 || cur_valid !== 1'b0) begin
            fails++; $display("FAIL abort_flags busy=%b valid=%b want 0,0", cur_busy, cur_valid); end
        tests++; if (cur_min !== 10'h3FF || cur_cnt !== 16'd0) begin
            fails++; $display("FAIL abort_regs min=%0d cnt=%0d want 1023,0", cur_min, cur_cnt); end
        @(negedge CLK); RST = 1'b0;
        repeat (6) @(negedge CLK);
        tests++; if (cur_valid !== 1'b0) begin fails++; $display("FAIL abort_valid got %b want 0", cur_valid); end
        run(400, 1'b0, lat, bok);
        tests++; if (!bok) begin fails++; $display("FAIL rerun_busy got low want high before Valid"); end
        tests++; if (cur_min !== 10'd0 || cur_cnt !== 16'd1) begin
            fails++; $display("FAIL rerun_result min=%0d cnt=%0d want 0,1", cur_min, cur_cnt); end
        tests++; if (cur_bp !== (BP ? 24'h000053 : 24'd0)) begin
            fails++; $display("FAIL rerun_bp got %h want %h", cur_bp, BP ? 24'h000053 : 24'd0); end
    endtask

    task automatic test_n6_max();
        int lat; bit bok;
        sel = 6;
        run(14500, 1'b0, lat, bok);
        tests++; if (lat > 14440) begin fails++; $display("FAIL n6_latency got %0d want <=14440", lat); end
        tests++; if (cur_min !== 10'd762) begin fails++; $display("FAIL n6_min got %0d want 762", cur_min); end
        tests++; if (cur_cnt !== 16'd720) begin fails++; $display("FAIL n6_cnt got %0d want 720", cur_cnt); end
        tests++; if (cur_bp !== (BP ? 24'd181896 : 24'd0)) begin
            fails++; $display("FAIL n6_bp got %h want %h", cur_bp, BP ? 24'd181896 : 24'd0); end
    endtask

    initial begin
        int ref_lat;
        test_reset();
        test_n2();
        test_n3();
        test_n4(ref_lat);
        test_start_during_next(ref_lat);
        test_reset_mid_eval();
        test_n6_max();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
